// File: rtl/cxu_mac_pkg.sv
// Shared definitions for the stateful multiply-accumulate CXU: function codes,
// status codes, controller states and the carry-producing accumulate helper.
package cxu_mac_pkg;

   localparam int DATA_W = 32;

   localparam logic [2:0] FUNC_READ  = 3'd0;
   localparam logic [2:0] FUNC_WRITE = 3'd1;
   localparam logic [2:0] FUNC_ADD   = 3'd2;
   localparam logic [2:0] FUNC_MAC   = 3'd3;
   localparam logic [2:0] FUNC_CLR   = 3'd4;

   localparam logic [3:0] STATUS_OK      = 4'h0;
   localparam logic [3:0] STATUS_ILLEGAL = 4'h1;
   localparam logic [3:0] STATUS_CARRY   = 4'h2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // Unsigned modulo-2^DATA_W add; the extra MSB is the carry-out.
   function automatic logic [DATA_W:0] acc_add(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
      return {1'b0, a} + {1'b0, b};
   endfunction

endpackage

// File: rtl/cxu_mac_seqmul.sv
// Iterative shift-add multiplier: DATA_W iterations after start, one per cycle.
// done and product are presented combinationally during the final iteration.
module cxu_mac_seqmul #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic              done,
   output logic [DATA_W-1:0] product
);

   localparam int CNT_W = $clog2(DATA_W);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

   logic              busy;
   logic [CNT_W-1:0]  count;
   logic [DATA_W-1:0] mcand;
   logic [DATA_W-1:0] mplier;
   logic [DATA_W-1:0] partial;
   logic [DATA_W-1:0] partial_nxt;

   assign partial_nxt = mplier[0] ? (partial + mcand) : partial;
   assign done        = busy && (count == LAST);
   assign product     = partial_nxt;

   // Operand/partial registers are only meaningful while busy, so only the
   // control state is cleared by reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy  <= 1'b0;
         count <= '0;
      end else if (start) begin
         busy  <= 1'b1;
         count <= '0;
      end else if (busy) begin
         count <= count + 1'b1;
         if (count == LAST) busy <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (start) begin
         mcand   <= a;
         mplier  <= b;
         partial <= '0;
      end else if (busy) begin
         mcand   <= mcand << 1;
         mplier  <= mplier >> 1;
         partial <= partial_nxt;
      end
   end

endmodule

// File: rtl/cxu_mac.sv
// Multiply-accumulate CXU: per-context accumulator bank, request decode and
// IDLE/MUL/DONE handshake controller with registered response and status.
module cxu_mac
   import cxu_mac_pkg::*;
#(
   parameter int N_STATES = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cxu_valid,
   input  logic [2:0]        cxu_func,
   input  logic [1:0]        cxu_state_id,
   input  logic [DATA_W-1:0] cxu_data0,
   input  logic [DATA_W-1:0] cxu_data1,
   output logic              cxu_ready,
   output logic [DATA_W-1:0] cxu_response,
   output logic [3:0]        cxu_status
);

   state_e            state;
   logic [DATA_W-1:0] acc [N_STATES];
   logic [1:0]        sid_q;

   logic              legal;
   logic              mac_start;
   logic              mul_done;
   logic              acc_wr;
   logic [DATA_W-1:0] acc_cur;
   logic [DATA_W-1:0] acc_mac;
   logic [DATA_W-1:0] acc_nxt;
   logic [DATA_W-1:0] resp_nxt;
   logic [DATA_W-1:0] product;
   logic [3:0]        status_nxt;
   logic [DATA_W:0]   add_sum;
   logic [DATA_W:0]   mac_sum;

   // Context reads go through an explicit mux so out-of-range ids never index the bank.
   always_comb begin
      acc_cur = '0;
      acc_mac = '0;
      for (int i = 0; i < N_STATES; i++) begin
         if (int'(cxu_state_id) == i) acc_cur = acc[i];
         if (int'(sid_q) == i)        acc_mac = acc[i];
      end
   end

   assign legal     = (cxu_func <= FUNC_CLR) && (int'(cxu_state_id) < N_STATES);
   assign mac_start = (state == ST_IDLE) && cxu_valid && legal && (cxu_func == FUNC_MAC);
   assign add_sum   = acc_add(acc_cur, cxu_data0);
   assign mac_sum   = acc_add(acc_mac, product);

   always_comb begin
      acc_wr     = 1'b0;
      acc_nxt    = acc_cur;
      resp_nxt   = '0;
      status_nxt = STATUS_ILLEGAL;
      if (legal) begin
         status_nxt = STATUS_OK;
         case (cxu_func)
            FUNC_READ: resp_nxt = acc_cur;
            FUNC_WRITE: begin
               acc_wr   = 1'b1;
               acc_nxt  = cxu_data0;
               resp_nxt = acc_cur;
            end
            FUNC_ADD: begin
               acc_wr     = 1'b1;
               acc_nxt    = add_sum[DATA_W-1:0];
               resp_nxt   = add_sum[DATA_W-1:0];
               status_nxt = add_sum[DATA_W] ? STATUS_CARRY : STATUS_OK;
            end
            FUNC_CLR: begin
               acc_wr   = 1'b1;
               acc_nxt  = '0;
               resp_nxt = acc_cur;
            end
            default: resp_nxt = '0;
         endcase
      end
   end

   cxu_mac_seqmul #(
      .DATA_W (DATA_W)
   ) u_seqmul (
      .clk     (clk),
      .rst     (rst),
      .start   (mac_start),
      .a       (cxu_data0),
      .b       (cxu_data1),
      .done    (mul_done),
      .product (product)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= ST_IDLE;
         cxu_ready    <= 1'b0;
         cxu_response <= '0;
         cxu_status   <= STATUS_OK;
         sid_q        <= '0;
         for (int i = 0; i < N_STATES; i++) acc[i] <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (cxu_valid) begin
                  sid_q <= cxu_state_id;
                  if (mac_start) begin
                     state <= ST_MUL;
                  end else begin
                     for (int i = 0; i < N_STATES; i++)
                        if (acc_wr && int'(cxu_state_id) == i) acc[i] <= acc_nxt;
                     cxu_response <= resp_nxt;
                     cxu_status   <= status_nxt;
                     cxu_ready    <= 1'b1;
                     state        <= ST_DONE;
                  end
               end
            end
            ST_MUL: begin
               if (mul_done) begin
                  for (int i = 0; i < N_STATES; i++)
                     if (int'(sid_q) == i) acc[i] <= mac_sum[DATA_W-1:0];
                  cxu_response <= mac_sum[DATA_W-1:0];
                  cxu_status   <= mac_sum[DATA_W] ? STATUS_CARRY : STATUS_OK;
                  cxu_ready    <= 1'b1;
                  state        <= ST_DONE;
               end
            end
            // Whether the switch takes the response or withdraws, the commit stands.
            ST_DONE: begin
               cxu_ready <= 1'b0;
               state     <= ST_IDLE;
            end
            default: begin
               cxu_ready <= 1'b0;
               state     <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cxu_mac.sv
// Randomized and directed bench for cxu_mac against a behavioural accumulator model.
module tb_cxu_mac;

   localparam int NS = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        cxu_valid;
   logic [2:0]  cxu_func;
   logic [1:0]  cxu_state_id;
   logic [31:0] cxu_data0;
   logic [31:0] cxu_data1;
   logic        cxu_ready;
   logic [31:0] cxu_response;
   logic [3:0]  cxu_status;

   logic        v2;
   logic [2:0]  f2;
   logic [1:0]  id2;
   logic [31:0] a2;
   logic        rdy2;
   logic [31:0] r2;
   logic [3:0]  s2;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int exp_cyc = -100;
   logic [31:0] exp_resp;
   logic [3:0]  exp_st;
   bit mon_en = 1'b0;
   logic [31:0] model_acc [NS];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   cxu_mac #(.N_STATES(NS)) dut (
      .clk(clk), .rst(rst), .cxu_valid(cxu_valid), .cxu_func(cxu_func),
      .cxu_state_id(cxu_state_id), .cxu_data0(cxu_data0), .cxu_data1(cxu_data1),
      .cxu_ready(cxu_ready), .cxu_response(cxu_response), .cxu_status(cxu_status)
   );

   cxu_mac #(.N_STATES(2)) dut2 (
      .clk(clk), .rst(rst), .cxu_valid(v2), .cxu_func(f2),
      .cxu_state_id(id2), .cxu_data0(a2), .cxu_data1(32'h0),
      .cxu_ready(rdy2), .cxu_response(r2), .cxu_status(s2)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      tests++;
      if (act !== want) begin
         fails++;
         $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, want, cyc);
      end
   endtask

   // Expected outcome of one request, from the functional rules alone.
   function automatic void model_req(input logic [2:0] f, input logic [1:0] id,
                                     input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] r, output logic [3:0] s,
                                     output int lat);
      logic [32:0] sum;
      logic [63:0] prod;
      lat = 1;
      r   = 32'h0;
      s   = 4'h1;
      if (f <= 3'd4 && int'(id) < NS) begin
         s = 4'h0;
         case (f)
            3'd0: r = model_acc[id];
            3'd1: begin r = model_acc[id]; model_acc[id] = a; end
            3'd2: begin
               sum = {1'b0, model_acc[id]} + {1'b0, a};
               model_acc[id] = sum[31:0];
               r = sum[31:0];
               s = sum[32] ? 4'h2 : 4'h0;
            end
            3'd3: begin
               prod = {32'h0, a} * {32'h0, b};
               sum  = {1'b0, model_acc[id]} + {1'b0, prod[31:0]};
               model_acc[id] = sum[31:0];
               r = sum[31:0];
               s = sum[32] ? 4'h2 : 4'h0;
               lat = 33;
            end
            default: begin r = model_acc[id]; model_acc[id] = 32'h0; end
         endcase
      end
   endfunction

   // Single compare process: ready must be high exactly in the expected cycle.
   always @(negedge clk) begin
      if (mon_en) begin
         chk("ready", {31'h0, cxu_ready}, {31'h0, (cyc == exp_cyc)});
         if (cyc == exp_cyc) begin
            chk("response", cxu_response, exp_resp);
            chk("status", {28'h0, cxu_status}, {28'h0, exp_st});
         end
      end
   end

   task automatic req(input logic [2:0] f, input logic [1:0] id, input logic [31:0] a,
                      input logic [31:0] b, input bit drop,
                      output logic [31:0] got_r, output logic [3:0] got_s);
      logic [31:0] r;
      logic [3:0]  s;
      int lat;
      int k;
      bit seen;
      model_req(f, id, a, b, r, s, lat);
      @(negedge clk);
      cxu_valid = 1'b1; cxu_func = f; cxu_state_id = id; cxu_data0 = a; cxu_data1 = b;
      k = cyc;
      exp_resp = r; exp_st = s; exp_cyc = k + lat;
      seen = 1'b0;
      got_r = 32'h0; got_s = 4'h0;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         cxu_data0 = $urandom;
         cxu_data1 = $urandom;
         if (cxu_ready) begin seen = 1'b1; break; end
      end
      if (!seen) begin
         chk("ready_timeout", 32'h0, 32'h1);
      end else begin
         got_r = cxu_response;
         got_s = cxu_status;
         chk("latency", cyc - k, lat);
      end
      if (drop) cxu_valid = 1'b0;
      @(negedge clk);
      cxu_valid = 1'b0;
      @(negedge clk);
   endtask

   task automatic req2(input logic [2:0] f, input logic [1:0] id, input logic [31:0] a,
                       input logic [31:0] want_r, input logic [3:0] want_s);
      @(negedge clk);
      v2 = 1'b1; f2 = f; id2 = id; a2 = a;
      @(negedge clk);
      chk("n2_ready", {31'h0, rdy2}, 32'h1);
      chk("n2_response", r2, want_r);
      chk("n2_status", {28'h0, s2}, {28'h0, want_s});
      v2 = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] gr;
      logic [3:0]  gs;
      logic [2:0]  f;
      logic [1:0]  id;
      logic [31:0] a, b;
      int k;

      rst = 1'b1; cxu_valid = 1'b0; cxu_func = 3'd0; cxu_state_id = 2'd0;
      cxu_data0 = 32'h0; cxu_data1 = 32'h0;
      v2 = 1'b0; f2 = 3'd0; id2 = 2'd0; a2 = 32'h0;
      for (int i = 0; i < NS; i++) model_acc[i] = 32'h0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("rst_ready", {31'h0, cxu_ready}, 32'h0);
      chk("rst_response", cxu_response, 32'h0);
      chk("rst_status", {28'h0, cxu_status}, 32'h0);
      mon_en = 1'b1;
      for (int i = 0; i < NS; i++) begin
         req(3'd0, 2'(i), 32'h0, 32'h0, 1'b0, gr, gs);
         chk("rst_acc", gr, 32'h0);
      end

      req(3'd1, 2'd1, 32'h12345678, 32'h0, 1'b0, gr, gs);
      chk("write_old", gr, 32'h0);
      chk("write_st", {28'h0, gs}, 32'h0);
      req(3'd0, 2'd1, 32'h0, 32'h0, 1'b0, gr, gs);
      chk("read_back", gr, 32'h12345678);

      req(3'd1, 2'd0, 32'd5, 32'h0, 1'b0, gr, gs);
      req(3'd3, 2'd0, 32'd7, 32'd9, 1'b0, gr, gs);
      chk("mac_basic", gr, 32'h44);
      chk("mac_basic_st", {28'h0, gs}, 32'h0);

      req(3'd1, 2'd2, 32'hFFFFFFFF, 32'h0, 1'b0, gr, gs);
      req(3'd2, 2'd2, 32'd2, 32'h0, 1'b0, gr, gs);
      chk("add_wrap", gr, 32'h1);
      chk("add_carry_st", {28'h0, gs}, 32'h2);

      req(3'd4, 2'd3, 32'h0, 32'h0, 1'b0, gr, gs);
      req(3'd3, 2'd3, 32'h10000, 32'h10000, 1'b0, gr, gs);
      chk("mac_trunc", gr, 32'h0);
      chk("mac_trunc_st", {28'h0, gs}, 32'h0);

      req(3'd1, 2'd3, 32'hCAFE, 32'h0, 1'b0, gr, gs);
      req(3'd6, 2'd3, 32'h1111, 32'h2222, 1'b0, gr, gs);
      chk("illegal_resp", gr, 32'h0);
      chk("illegal_st", {28'h0, gs}, 32'h1);
      req(3'd0, 2'd3, 32'h0, 32'h0, 1'b0, gr, gs);
      chk("illegal_keep", gr, 32'hCAFE);

      // Reset in the middle of a MAC: no commit, no ready, bank cleared.
      req(3'd1, 2'd0, 32'd3, 32'h0, 1'b0, gr, gs);
      @(negedge clk);
      cxu_valid = 1'b1; cxu_func = 3'd3; cxu_state_id = 2'd0;
      cxu_data0 = 32'd5; cxu_data1 = 32'd6;
      k = cyc;
      while (cyc < k + 11) @(negedge clk);
      rst = 1'b1; cxu_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < NS; i++) model_acc[i] = 32'h0;
      chk("abort_response", cxu_response, 32'h0);
      chk("abort_status", {28'h0, cxu_status}, 32'h0);
      repeat (40) @(negedge clk);
      req(3'd0, 2'd0, 32'h0, 32'h0, 1'b0, gr, gs);
      chk("abort_acc", gr, 32'h0);

      req(3'd1, 2'd1, 32'd1, 32'h0, 1'b0, gr, gs);
      req(3'd2, 2'd1, 32'd4, 32'h0, 1'b1, gr, gs);
      chk("drop_resp", gr, 32'd5);
      repeat (3) @(negedge clk);
      req(3'd0, 2'd1, 32'h0, 32'h0, 1'b0, gr, gs);
      chk("drop_commit", gr, 32'd5);

      for (int n = 0; n < 150; n++) begin
         f  = 3'($urandom_range(0, 7));
         id = 2'($urandom_range(0, 3));
         a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
         b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
         req(f, id, a, b, ($urandom_range(0, 3) == 0), gr, gs);
      end
      mon_en = 1'b0;

      req2(3'd0, 2'd3, 32'h0, 32'h0, 4'h1);
      req2(3'd1, 2'd1, 32'hAA, 32'h0, 4'h0);
      req2(3'd0, 2'd1, 32'h0, 32'hAA, 4'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/cxu_mac.md
# cxu_mac

Stateful multiply-accumulate custom-function unit (CXU) sitting directly downstream of the CX switch on one of its CXU ports. Consumes the switch's per-CXU valid, the shared operand/state-id buses and a function code, and returns a 32-bit response plus 4-bit status with a ready pulse. Holds one 32-bit accumulator per CX state context. MAC uses an iterative shift-add multiplier, so MAC latency is multi-cycle; all other functions complete in one cycle.

## Interface
- N_STATES, 4, number of accumulator contexts (indexed by cxu_state_id; ids >= N_STATES are illegal)
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- cxu_valid  in  1  request valid from switch; level, held until ready seen
- cxu_func  in  3  function code
- cxu_state_id  in  2  accumulator context select
- cxu_data0  in  32  operand A
- cxu_data1  in  32  operand B
- cxu_ready  out  1  response valid this cycle; the switch samples response/status when ready=1
- cxu_response  out  32  result data
- cxu_status  out  4  result status

## Operation
- Functions: 0 READ (resp=acc); 1 WRITE (acc=A, resp=old acc); 2 ADD (acc=acc+A, resp=new acc); 3 MAC (acc=acc+low32(A*B), resp=new acc); 4 CLR (acc=0, resp=old acc); 5-7 illegal.
- Arithmetic is modulo 2^32, unsigned; product truncated to the low 32 bits.
- Status: 4'h0 OK; 4'h1 illegal func or state_id >= N_STATES (no accumulator change, resp=0); 4'h2 OK with carry-out from the ADD/MAC accumulate (accumulator still updated with the wrapped value).
- FSM states: IDLE, MUL, DONE.
  - IDLE: ready=0. On cxu_valid, latch func, state_id, A, B. Single-cycle/illegal func: compute, commit accumulator, load resp/status registers, go to DONE. MAC: load multiplicand=A, multiplier=B, partial=0, count=0, go to MUL.
  - MUL: each cycle, if multiplier[0] then partial += multiplicand; multiplicand <<= 1; multiplier >>= 1; count++. After the 32nd iteration (count==31), commit acc+partial and load resp/status, go to DONE.
  - DONE: ready=1, response/status driven from registers. If cxu_valid=1, the handshake completes this cycle; go to IDLE. If cxu_valid=0 (request withdrawn), drop response; go to IDLE. In both cases the accumulator commit stands.
- Accumulators commit only on the transition into DONE; no partial update is ever visible.
- Response/status registers hold their values outside DONE but are qualified only by ready.

## Timing
- Reset: state IDLE, cxu_ready=0, cxu_response=0, cxu_status=0, all accumulators 0, count=0.
- Reset mid-MUL or in DONE: abort, no accumulator commit, IDLE next cycle.
- Single-cycle func: valid first seen in cycle t (IDLE); ready=1 in t+1.
- MAC: valid seen in t; MUL occupies t+1..t+32; ready=1 in t+33. Latency is fixed and data-independent.
- Back-to-back: DONE goes to IDLE; the earliest next request is accepted in the cycle after DONE. cxu_valid in the cycle immediately following DONE belongs to a new request only if the switch has re-issued it; the switch's own AWAIT_RESP/AWAIT_REQ cycles guarantee a gap of at least 2 cycles.
- Inputs are sampled only in IDLE; operand changes during MUL/DONE are ignored.

## Structure
- Package cxu_mac_pkg: func code constants, status code constants (OK, ILLEGAL, CARRY), FSM state enum.
- One sub-module: cxu_mac_seqmul, the 32-iteration shift-add multiplier (start, A, B -> done pulse, 32-bit product). The top handles the FSM, accumulator bank, decode and response registers.

## Test plan
- Reset, then WRITE ctx1 A=0x12345678 -> ready 1 cycle after valid, resp=0, status 0; subsequent READ ctx1 -> resp=0x12345678.
- MAC ctx0 with acc=5, A=7, B=9 -> ready exactly 33 cycles after valid first seen, resp=68 (0x44), status 0.
- ADD ctx2 with acc=0xFFFFFFFF, A=2 -> resp=0x00000001, status 4'h2; MAC with A=0x10000, B=0x10000 from acc=0 -> resp=0, status 0 (truncation).
- func=6 on ctx3 -> resp=0, status 4'h1, ctx3 accumulator unchanged; state_id=3 with N_STATES=2 -> status 4'h1.
- Assert rst at MUL cycle 10 of a MAC on ctx0 (acc=3) -> ready stays 0, READ ctx0 afterwards returns 0 (reset clears the bank).
- Drop valid while in DONE after ADD ctx1 A=4 from acc=1 -> IDLE next cycle, no ready re-assert; READ ctx1 -> 5.
